addsub_unit: RTL and testbench
==============================

# addsub_unit

Multi-cycle add/subtract engine that sits directly upstream of the datapath result register. It accepts two operands and an opcode and computes the sum or difference CHUNK_WIDTH bits per cycle, LSB chunk first. It then presents result and flags with a one-cycle `done` pulse, which the downstream register uses as its `enable`, with `result` on its `din`.

## Interface
- `DATA_WIDTH`, 16: operand/result width; must be a multiple of CHUNK_WIDTH.
- `CHUNK_WIDTH`, 4: bits added per cycle; N = DATA_WIDTH/CHUNK_WIDTH calculation cycles.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  1  0 = add (a+b), 1 = subtract (a−b).
- `a`  in  DATA_WIDTH  operand A, captured on accepted start.
- `b`  in  DATA_WIDTH  operand B, captured on accepted start.
- `busy`  out  1  high while chunks are being computed.
- `done`  out  1  one-cycle pulse: result/flags valid (drives downstream enable).
- `result`  out  DATA_WIDTH  registered result; held until the next `done`.
- `carry`  out  1  carry out of the MSB; for subtract, 1 = no borrow.
- `overflow`  out  1  two's-complement signed overflow.
- `zero`  out  1  `result` == 0.

## Operation
- FSM states IDLE, CALC, DONE:
  - IDLE, start=1 → CALC.
  - CALC → CALC while chunk index < N−1, otherwise → DONE.
  - DONE, start=1 → CALC; start=0 → IDLE.
- Accepting start:
  - Latch `a`.
  - Latch b_eff = op ? ~b : b.
  - Set carry_in = op (two's-complement subtract).
  - Clear the chunk index and the accumulator.
- Each CALC cycle:
  - Add chunk k of a and b_eff plus the running carry.
  - Write the sum bits into accumulator chunk k.
  - Register the carry out.
  - Increment k.
- On leaving CALC, update outputs:
  - `result` ← accumulator.
  - `carry` ← final carry.
  - `overflow` ← (a[MSB] == b_eff[MSB]) && (result[MSB] != a[MSB]).
  - `zero` ← (accumulator == 0).
- Operand and opcode changes during CALC are ignored; only latched copies are used.
- `start` during CALC is ignored and not queued.
- `start` in DONE is accepted, so back-to-back operations are allowed.
- All arithmetic is modulo 2^DATA_WIDTH; no saturation.

## Timing
- Reset values:
  - State = IDLE.
  - `busy` = 0, `done` = 0.
  - `result` = 0, `carry` = 0, `overflow` = 0, `zero` = 0.
  - Chunk index and accumulator = 0.
- `start` high in cycle 0 (IDLE or DONE) gives:
  - `busy` = 1 in cycles 1..N.
  - `done` = 1 in cycle N+1 only.
  - Latency N+1 cycles (5 at defaults).
- `result` and flags change only in the same cycle `done` rises; they are stable at every other time.
- `busy` and `done` are never high in the same cycle.
- Reset asserted in any cycle has priority over start and chunk progress. The next cycle matches the reset values, the in-flight operation is abandoned, and no `done` is produced.
- Throughput: one result per N+1 cycles when `start` is held high continuously.

## Structure
- Shared package `addsub_pkg` holds:
  - State encoding: IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2.
  - OP_ADD = 1'b0, OP_SUB = 1'b1.
- Sub-module `addsub_chunk`: combinational CHUNK_WIDTH-bit adder with ports `x`, `y`, `cin`, `sum`, `cout`, instantiated once.
- Top level contains the FSM, chunk index counter, latched operands, accumulator and output registers.

## Test plan
- Add, defaults: a=0003, b=0004, op=0, start in cycle 0 → `busy` cycles 1–4, `done` in cycle 5 only. result=0007, carry=0, overflow=0, zero=0.
- Subtract to zero: a=0005, b=0005, op=1 → result=0000, carry=1, zero=1, overflow=0.
- Signed overflow: a=7FFF, b=0001, op=0 → result=8000, overflow=1, carry=0. Also a=8000, b=0001, op=1 → result=7FFF, overflow=1, carry=1.
- Full carry ripple across chunks: a=FFFF, b=0001, op=0 → result=0000, carry=1, zero=1, overflow=0.
- Handshake:
  - Change a/b and pulse start during cycles 2–3 → first result is unaffected and no extra `done` appears.
  - start held high through DONE → second `done` arrives exactly 5 cycles after the first.
- Reset mid-operation: rst=1 in cycle 2 → cycle 3 has busy=0, done=0, result=0. A fresh a=0010, b=0001, op=1 then yields result=000F.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared encodings for the chunked add/subtract engine.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK_WIDTH-bit adder slice with carry in/out.
module addsub_chunk #(
  parameter int CHUNK_WIDTH = 4
) (
  input  logic [CHUNK_WIDTH-1:0] x,
  input  logic [CHUNK_WIDTH-1:0] y,
  input  logic                   cin,
  output logic [CHUNK_WIDTH-1:0] sum,
  output logic                   cout
);

  logic [CHUNK_WIDTH:0] w_total;

  assign w_total = {1'b0, x} + {1'b0, y} + {{CHUNK_WIDTH{1'b0}}, cin};
  assign sum     = w_total[CHUNK_WIDTH-1:0];
  assign cout    = w_total[CHUNK_WIDTH];

endmodule

// File: rtl/addsub_unit.sv
// Multi-cycle add/subtract: one CHUNK_WIDTH slice per cycle, LSB first,
// result and flags presented with a single-cycle done pulse.
module addsub_unit
  import addsub_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int CHUNK_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  overflow,
  output logic                  zero
);

  localparam int N     = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // Signed overflow: like-signed operands producing an opposite-signed result.
  function automatic logic calc_overflow(input logic a_msb, input logic b_msb,
                                         input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DATA_WIDTH-1:0]  r_a;
  logic [DATA_WIDTH-1:0]  r_b_eff;
  logic [DATA_WIDTH-1:0]  r_acc;
  logic [DATA_WIDTH-1:0]  w_acc_upd;
  logic                   r_cy;
  logic [IDX_W-1:0]       r_idx;
  logic [DATA_WIDTH-1:0]  r_result;
  logic                   r_carry;
  logic                   r_overflow;
  logic                   r_zero;
  logic [CHUNK_WIDTH-1:0] w_sum;
  logic                   w_cout;
  logic                   w_accept;
  logic                   w_last;

  assign w_accept = start && (r_state != CALC);
  assign w_last   = (r_state == CALC) && (r_idx == LAST_IDX);

  addsub_chunk #(
    .CHUNK_WIDTH(CHUNK_WIDTH)
  ) u_chunk (
    .x   (r_a[int'(r_idx)*CHUNK_WIDTH +: CHUNK_WIDTH]),
    .y   (r_b_eff[int'(r_idx)*CHUNK_WIDTH +: CHUNK_WIDTH]),
    .cin (r_cy),
    .sum (w_sum),
    .cout(w_cout)
  );

  // Accumulator with the current chunk's sum merged in; on the last chunk
  // this is the complete result, so outputs load it directly.
  always_comb begin
    w_acc_upd = r_acc;
    w_acc_upd[int'(r_idx)*CHUNK_WIDTH +: CHUNK_WIDTH] = w_sum;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = CALC;
      CALC:    if (r_idx == LAST_IDX) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? CALC : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= '0;
      r_b_eff    <= '0;
      r_acc      <= '0;
      r_cy       <= 1'b0;
      r_idx      <= '0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= a;
        r_b_eff <= (op == OP_SUB) ? ~b : b;
        r_cy    <= (op == OP_SUB);
        r_idx   <= '0;
        r_acc   <= '0;
      end else if (r_state == CALC) begin
        r_acc <= w_acc_upd;
        r_cy  <= w_cout;
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_last) begin
        r_result   <= w_acc_upd;
        r_carry    <= w_cout;
        r_overflow <= calc_overflow(r_a[DATA_WIDTH-1], r_b_eff[DATA_WIDTH-1],
                                    w_acc_upd[DATA_WIDTH-1]);
        r_zero     <= (w_acc_upd == '0);
      end
    end
  end

  assign busy     = (r_state == CALC);
  assign done     = (r_state == DONE);
  assign result   = r_result;
  assign carry    = r_carry;
  assign overflow = r_overflow;
  assign zero     = r_zero;

endmodule

// File: tb/tb_addsub_unit.sv
// Self-checking bench for addsub_unit against an integer-arithmetic model.
module tb_addsub_unit;

  localparam int DW = 16;
  localparam int CW = 4;
  localparam int N  = DW / CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          op = 1'b0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          busy, done, carry, overflow, zero;
  logic [DW-1:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addsub_unit #(
    .DATA_WIDTH (DW),
    .CHUNK_WIDTH(CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .carry   (carry),
    .overflow(overflow),
    .zero    (zero)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain modular and signed integer arithmetic.
  function automatic void model(input logic [DW-1:0] ta, input logic [DW-1:0] tb,
                                input logic top, output logic [DW-1:0] r,
                                output logic c, output logic v, output logic z);
    int ua, ub, sa, sb, sr;
    ua = int'(ta);
    ub = int'(tb);
    sa = int'($signed(ta));
    sb = int'($signed(tb));
    if (top) begin
      r  = DW'(ua - ub);
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = DW'(ua + ub);
      c  = ((ua + ub) >= (1 << DW));
      sr = sa + sb;
    end
    v = (sr > 32767) || (sr < -32768);
    z = (r == '0);
  endfunction

  // One full operation from IDLE/DONE, checking timing, hold and final values.
  task automatic do_op(input logic [DW-1:0] ta, input logic [DW-1:0] tb,
                       input logic top, input string nm);
    logic [DW-1:0] er, prev;
    logic ec, ev, ez;
    model(ta, tb, top, er, ec, ev, ez);
    prev  = result;
    a     = ta;
    b     = tb;
    op    = top;
    start = 1'b1;
    tick;
    start = 1'b0;
    a     = DW'($urandom);
    b     = DW'($urandom);
    op    = ~top;
    for (int c = 1; c <= N; c++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || result !== prev) begin
        errors++;
        $display("FAIL %s calc cycle %0d: busy=%b done=%b result=%h, expected busy=1 done=0 result=%h",
                 nm, c, busy, done, result, prev);
      end
      tick;
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL %s done cycle: busy=%b done=%b, expected busy=0 done=1", nm, busy, done);
    end
    checks++;
    if (result !== er) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", nm, result, er);
    end
    checks++;
    if (carry !== ec || overflow !== ev || zero !== ez) begin
      errors++;
      $display("FAIL %s flags: got c=%b v=%b z=%b expected c=%b v=%b z=%b",
               nm, carry, overflow, zero, ec, ev, ez);
    end
    tick;
    checks++;
    if (done !== 1'b0 || result !== er) begin
      errors++;
      $display("FAIL %s after done: done=%b result=%h expected done=0 result=%h",
               nm, done, result, er);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset busy/done: busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (result !== '0 || carry !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: result=%h c=%b v=%b z=%b expected all zero",
               result, carry, overflow, zero);
    end
  endtask

  task automatic test_add;
    do_op(16'h0003, 16'h0004, 1'b0, "add_3_4");
  endtask

  task automatic test_sub_zero;
    do_op(16'h0005, 16'h0005, 1'b1, "sub_to_zero");
  endtask

  task automatic test_overflow;
    do_op(16'h7FFF, 16'h0001, 1'b0, "ovf_add");
    do_op(16'h8000, 16'h0001, 1'b1, "ovf_sub");
  endtask

  task automatic test_carry_ripple;
    do_op(16'hFFFF, 16'h0001, 1'b0, "ripple");
    do_op(16'h0000, 16'h0001, 1'b1, "borrow_all");
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++)
      do_op(DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)), "random");
  endtask

  task automatic test_handshake;
    logic [DW-1:0] er;
    logic ec, ev, ez;
    model(16'h1234, 16'h0FF0, 1'b1, er, ec, ev, ez);
    a = 16'h1234; b = 16'h0FF0; op = 1'b1; start = 1'b1;
    tick;                                   // cycle 1
    start = 1'b0;
    tick;                                   // cycle 2
    a = 16'hAAAA; b = 16'h5555; op = 1'b0; start = 1'b1;
    tick;                                   // cycle 3
    a = 16'h0F0F; b = 16'hF0F0;
    tick;                                   // cycle 4
    start = 1'b0;
    tick;                                   // cycle 5
    checks++;
    if (done !== 1'b1 || result !== er || carry !== ec || overflow !== ev || zero !== ez) begin
      errors++;
      $display("FAIL handshake result: done=%b result=%h c=%b v=%b z=%b expected 1 %h %b %b %b",
               done, result, carry, overflow, zero, er, ec, ev, ez);
    end
    for (int c = 0; c < 2 * N; c++) begin
      tick;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL handshake extra activity +%0d: busy=%b done=%b expected 0 0", c, busy, done);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] er1, er2;
    logic c1, v1, z1, c2, v2, z2;
    int cyc;
    model(16'h4321, 16'h1111, 1'b0, er1, c1, v1, z1);
    model(16'h0100, 16'h0200, 1'b1, er2, c2, v2, z2);
    a = 16'h4321; b = 16'h1111; op = 1'b0; start = 1'b1;
    tick;
    cyc = 1;
    a = 16'h0100; b = 16'h0200; op = 1'b1;
    while (done !== 1'b1 && cyc < 20) begin
      tick;
      cyc++;
    end
    checks++;
    if (cyc !== N + 1 || result !== er1 || carry !== c1) begin
      errors++;
      $display("FAIL b2b first: cycle=%0d result=%h c=%b expected cycle=%0d result=%h c=%b",
               cyc, result, carry, N + 1, er1, c1);
    end
    cyc = 0;
    tick;
    cyc++;
    while (done !== 1'b1 && cyc < 20) begin
      tick;
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (cyc !== N + 1) begin
      errors++;
      $display("FAIL b2b spacing: got %0d cycles expected %0d", cyc, N + 1);
    end
    checks++;
    if (result !== er2 || carry !== c2 || overflow !== v2 || zero !== z2) begin
      errors++;
      $display("FAIL b2b second: result=%h c=%b v=%b z=%b expected %h %b %b %b",
               result, carry, overflow, zero, er2, c2, v2, z2);
    end
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b idle after: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid;
    a = 16'h1357; b = 16'h2468; op = 1'b0; start = 1'b1;
    tick;                                   // cycle 1
    start = 1'b0;
    tick;                                   // cycle 2
    rst = 1'b1;
    tick;                                   // cycle 3
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h expected 0 0 0000", busy, done, result);
    end
    for (int c = 0; c < N + 2; c++) begin
      tick;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid abandoned op +%0d: busy=%b done=%b expected 0 0", c, busy, done);
      end
    end
    do_op(16'h0010, 16'h0001, 1'b1, "after_reset");
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub_zero;
    test_overflow;
    test_carry_ripple;
    test_handshake;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
